// File: rtl/count_connected_pkg.sv
// Shared types for the connected-component counting pipeline: graph word width
// and the FIFO entry layout (graph word plus per-graph tag).
package count_connected_pkg;

  localparam int GRAPH_WIDTH     = 128;
  // The entry layout has a fixed tag field; feeders with narrower tags zero-extend into it.
  localparam int MAX_EXTRA_WIDTH = 32;

  typedef struct packed {
    logic [GRAPH_WIDTH-1:0]     graph;
    logic [MAX_EXTRA_WIDTH-1:0] extra;
  } graph_entry_t;

endpackage

// File: rtl/count_connected_input_feeder_if.sv
// Producer/core-facing signal bundle of the input feeder. The slave modport is
// the feeder itself. The master modport is the environment that drives it.
interface count_connected_input_feeder_if
  import count_connected_pkg::*;
#(
  parameter int EXTRA_DATA_WIDTH = 10,
  parameter int FIFO_DEPTH       = 16
);

  logic [GRAPH_WIDTH-1:0]        writeGraph;
  logic [EXTRA_DATA_WIDTH-1:0]   writeExtra;
  logic                          writeValid;
  logic                          writeReady;
  logic                          request;
  logic [GRAPH_WIDTH-1:0]        graphOut;
  logic                          graphAvailable;
  logic [EXTRA_DATA_WIDTH-1:0]   extraDataOut;
  logic [$clog2(FIFO_DEPTH):0]   occupancy;

  modport slave (
    input  writeGraph, writeExtra, writeValid, request,
    output writeReady, graphOut, graphAvailable, extraDataOut, occupancy
  );

  modport master (
    output writeGraph, writeExtra, writeValid, request,
    input  writeReady, graphOut, graphAvailable, extraDataOut, occupancy
  );

endinterface

// File: rtl/count_connected_input_feeder_fifo.sv
// feeder_fifo: graph-entry FIFO with block-RAM storage and a registered read port.
// writeReady is registered from the next occupancy, so it never depends on the pop input.
module feeder_fifo
  import count_connected_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push_valid,
  input  graph_entry_t           i_push_entry,
  output logic                   o_ready,
  input  logic                   i_pop,
  output logic                   o_pop_fire,
  output graph_entry_t           o_rd_entry,
  output logic [$clog2(DEPTH):0] o_occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  graph_entry_t     r_mem [DEPTH];
  graph_entry_t     r_rd_entry;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_next;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;

  // Pops look only at the registered count, so a same-cycle push is never bypassed.
  assign w_push = i_push_valid & r_ready;
  assign w_pop  = i_pop & (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_ready <= (w_count_next != FULL_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_rd_entry <= r_mem[r_rd_ptr];
  end

  assign o_ready     = r_ready;
  assign o_pop_fire  = w_pop;
  assign o_rd_entry  = r_rd_entry;
  assign o_occupancy = r_count;

endmodule

// File: rtl/count_connected_input_feeder.sv
// count_connected_input_feeder: buffers graphs and returns one DATA_IN_LATENCY cycles
// after each core request. Optional feature macro: STARVATION_COUNTER_EN (starvedCount output).
module count_connected_input_feeder
  import count_connected_pkg::*;
#(
  parameter int EXTRA_DATA_WIDTH = 10,
  parameter int DATA_IN_LATENCY  = 4,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef STARVATION_COUNTER_EN
  output logic [31:0] starvedCount,
`endif
  count_connected_input_feeder_if.slave bus
);

  graph_entry_t                w_push_entry;
  graph_entry_t                w_rd_entry;
  logic                        w_write_ready;
  logic                        w_pop;
  logic [$clog2(FIFO_DEPTH):0] w_occupancy;

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.graph = bus.writeGraph;
    w_push_entry.extra = MAX_EXTRA_WIDTH'(bus.writeExtra);
  end

  feeder_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (bus.writeValid),
    .i_push_entry (w_push_entry),
    .o_ready      (w_write_ready),
    .i_pop        (bus.request),
    .o_pop_fire   (w_pop),
    .o_rd_entry   (w_rd_entry),
    .o_occupancy  (w_occupancy)
  );

  // Stage 1 is the RAM read register. Later stages carry data already zeroed when invalid.
  logic [DATA_IN_LATENCY:1] r_valid_pipe;
  graph_entry_t             r_entry_pipe [2:DATA_IN_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_pipe <= '0;
      for (int k = 2; k <= DATA_IN_LATENCY; k++) r_entry_pipe[k] <= '0;
    end else begin
      r_valid_pipe    <= {r_valid_pipe[DATA_IN_LATENCY-1:1], w_pop};
      r_entry_pipe[2] <= r_valid_pipe[1] ? w_rd_entry : '0;
      for (int k = 3; k <= DATA_IN_LATENCY; k++) r_entry_pipe[k] <= r_entry_pipe[k-1];
    end
  end

  assign bus.writeReady     = w_write_ready;
  assign bus.occupancy      = w_occupancy;
  assign bus.graphAvailable = r_valid_pipe[DATA_IN_LATENCY];
  assign bus.graphOut       = r_entry_pipe[DATA_IN_LATENCY].graph;
  assign bus.extraDataOut   = EXTRA_DATA_WIDTH'(r_entry_pipe[DATA_IN_LATENCY].extra);

`ifdef STARVATION_COUNTER_EN
  logic [31:0] r_starved_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starved_count <= '0;
    end else if (bus.request && (w_occupancy == '0) && (r_starved_count != '1)) begin
      r_starved_count <= r_starved_count + 1'b1;
    end
  end

  assign starvedCount = r_starved_count;
`endif

endmodule

// File: tb/tb_count_connected_input_feeder.sv
// Directed bench for count_connected_input_feeder (latency 4, depth 16, 10-bit tag).
// STARVATION_COUNTER_EN may be defined to also check starvedCount.
module tb_count_connected_input_feeder;

  logic clk;
  logic rst;

  count_connected_input_feeder_if #(.EXTRA_DATA_WIDTH(10), .FIFO_DEPTH(16)) bus_if ();

`ifdef STARVATION_COUNTER_EN
  logic [31:0] starved_count;
`endif

  count_connected_input_feeder #(
    .EXTRA_DATA_WIDTH (10),
    .DATA_IN_LATENCY  (4),
    .FIFO_DEPTH       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef STARVATION_COUNTER_EN
    .starvedCount (starved_count),
`endif
    .bus          (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] g, input logic [9:0] t);
    bus_if.writeGraph = g;
    bus_if.writeExtra = t;
    bus_if.writeValid = 1'b1;
    tick();
    bus_if.writeValid = 1'b0;
  endtask

  task automatic issue_request();
    bus_if.request = 1'b1;
    tick();
    bus_if.request = 1'b0;
  endtask

  function automatic logic [127:0] mk_graph(input int i);
    return {32'(i), 32'hC0DE0000 | 32'(i), 32'(i * 3 + 1), 32'hFEED0000 ^ 32'(i)};
  endfunction

  // Scoreboard state for the streaming scenario.
  logic [137:0] exp_q [$];
  logic [137:0] pe;
  logic         m_v [1:4];
  logic [127:0] m_g [1:4];
  logic [9:0]   m_t [1:4];
  logic [127:0] cur_g;
  logic [9:0]   cur_t;
  logic         want_push, req, acc, pop;
  int           pushed, n_resp, m_count;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    bus_if.writeGraph = '0;
    bus_if.writeExtra = '0;
    bus_if.writeValid = 1'b0;
    bus_if.request    = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ready", bus_if.writeReady, 0);
    check("rst_occ", bus_if.occupancy, 0);
    check("rst_avail", bus_if.graphAvailable, 0);
    check("rst_graph", bus_if.graphOut, 0);
    check("rst_extra", bus_if.extraDataOut, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", bus_if.writeReady, 1);
    $display("[TB] reset released");

    // Single push and request: response exactly 4 cycles later, one cycle wide
    push(128'h1, 10'd5);
    check("s1_occ_push", bus_if.occupancy, 1);
    issue_request();
    check("s1_occ_pop", bus_if.occupancy, 0);
    tick();
    tick();
    check("s1_early", bus_if.graphAvailable, 0);
    tick();
    check("s1_avail", bus_if.graphAvailable, 1);
    check("s1_graph", bus_if.graphOut, 128'h1);
    check("s1_extra", bus_if.extraDataOut, 5);
    tick();
    check("s1_avail_off", bus_if.graphAvailable, 0);
    check("s1_graph_off", bus_if.graphOut, 0);
    check("s1_extra_off", bus_if.extraDataOut, 0);
    $display("[TB] single push/request done");

    // Starved request on empty FIFO
    issue_request();
    tick();
    tick();
    tick();
    check("s2_avail", bus_if.graphAvailable, 0);
    check("s2_graph", bus_if.graphOut, 0);
`ifdef STARVATION_COUNTER_EN
    check("s2_starved", starved_count, 1);
`endif

    // Push into empty FIFO together with a request: no bypass
    bus_if.writeGraph = 128'hAB;
    bus_if.writeExtra = 10'd3;
    bus_if.writeValid = 1'b1;
    bus_if.request    = 1'b1;
    tick();
    bus_if.writeValid = 1'b0;
    bus_if.request    = 1'b0;
    tick();
    tick();
    tick();
    check("s2_nobypass_avail", bus_if.graphAvailable, 0);
    check("s2_nobypass_occ", bus_if.occupancy, 1);
`ifdef STARVATION_COUNTER_EN
    check("s2_starved2", starved_count, 2);
`endif
    issue_request();
    tick();
    tick();
    tick();
    check("s2_late_avail", bus_if.graphAvailable, 1);
    check("s2_late_graph", bus_if.graphOut, 128'hAB);
    check("s2_late_extra", bus_if.extraDataOut, 3);
    tick();
    $display("[TB] starvation and no-bypass done");

    // Fill to full, ignored write, push+pop at full, then back-to-back drain
    for (int i = 0; i < 16; i++) push(128'(100 + i), 10'(i));
    check("s3_full_ready", bus_if.writeReady, 0);
    check("s3_full_occ", bus_if.occupancy, 16);
    push(128'hDEAD, 10'h3FF);
    check("s3_ignored_occ", bus_if.occupancy, 16);
    bus_if.writeGraph = 128'hBEEF;
    bus_if.writeExtra = 10'h155;
    bus_if.writeValid = 1'b1;
    bus_if.request    = 1'b1;
    tick();
    bus_if.writeValid = 1'b0;
    bus_if.request    = 1'b0;
    check("s3_pushpop_occ", bus_if.occupancy, 15);
    check("s3_pushpop_ready", bus_if.writeReady, 1);
    for (int j = 0; j < 19; j++) begin
      bus_if.request = (j < 15);
      tick();
      if (j >= 2 && j <= 17) begin
        check("s3_drain_avail", bus_if.graphAvailable, 1);
        check("s3_drain_graph", bus_if.graphOut, 128'(100 + j - 2));
        check("s3_drain_extra", bus_if.extraDataOut, 128'(j - 2));
      end else begin
        check("s3_drain_idle", bus_if.graphAvailable, 0);
      end
    end
    bus_if.request = 1'b0;
    check("s3_drained_occ", bus_if.occupancy, 0);
    $display("[TB] full/drain done");

    // Streaming: 40 pushes with random requests against an in-order scoreboard
    pushed  = 0;
    n_resp  = 0;
    m_count = 0;
    exp_q.delete();
    for (int k = 1; k <= 4; k++) begin
      m_v[k] = 1'b0;
      m_g[k] = '0;
      m_t[k] = '0;
    end
    for (int c = 0; c < 200; c++) begin
      want_push = (pushed < 40);
      cur_g     = mk_graph(pushed);
      cur_t     = 10'(pushed);
      req       = (pushed < 40) ? ($urandom_range(0, 2) == 0) : 1'b1;
      bus_if.writeValid = want_push;
      bus_if.writeGraph = cur_g;
      bus_if.writeExtra = cur_t;
      bus_if.request    = req;
      acc = want_push && (m_count != 16);
      pop = req && (m_count != 0);
      pe  = '0;
      if (pop) pe = exp_q.pop_front();
      if (acc) begin
        exp_q.push_back({cur_g, cur_t});
        pushed++;
      end
      m_count = m_count + int'(acc) - int'(pop);
      tick();
      for (int k = 4; k >= 2; k--) begin
        m_v[k] = m_v[k-1];
        m_g[k] = m_g[k-1];
        m_t[k] = m_t[k-1];
      end
      m_v[1] = pop;
      m_g[1] = pop ? pe[137:10] : '0;
      m_t[1] = pop ? pe[9:0] : '0;
      check("s4_avail", bus_if.graphAvailable, m_v[4]);
      check("s4_graph", bus_if.graphOut, m_g[4]);
      check("s4_extra", bus_if.extraDataOut, m_t[4]);
      if (m_v[4]) n_resp++;
    end
    bus_if.writeValid = 1'b0;
    bus_if.request    = 1'b0;
    check("s4_pushed", pushed, 40);
    check("s4_responses", n_resp, 40);
    check("s4_occ", bus_if.occupancy, 0);
    $display("[TB] streaming done: %0d pushes, %0d responses", pushed, n_resp);

    // Reset with three responses in flight
    push(128'h11, 10'd1);
    push(128'h22, 10'd2);
    push(128'h33, 10'd3);
    bus_if.request = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("s5_rst_occ", bus_if.occupancy, 0);
    check("s5_rst_avail", bus_if.graphAvailable, 0);
    check("s5_rst_ready", bus_if.writeReady, 0);
    check("s5_rst_graph", bus_if.graphOut, 0);
    tick();
    tick();
    rst            = 1'b0;
    bus_if.request = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("s5_no_pulse", bus_if.graphAvailable, 0);
    end
    check("s5_occ_after", bus_if.occupancy, 0);
`ifdef STARVATION_COUNTER_EN
    check("s5_starved_clr", starved_count, 0);
`endif
    push(128'h77, 10'd7);
    issue_request();
    tick();
    tick();
    tick();
    check("s5_post_avail", bus_if.graphAvailable, 1);
    check("s5_post_graph", bus_if.graphOut, 128'h77);
    check("s5_post_extra", bus_if.extraDataOut, 7);
    tick();
    $display("[TB] reset mid-pipe done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
